// File: rtl/ocm_port_arbiter_pkg.sv
// OCM port arbiter shared definitions.
// Macro geometry, default requester count and arbiter state encoding.
package ocm_pkg;

    localparam int OCM_AW   = 12;
    localparam int OCM_DW   = 128;
    localparam int OCM_NREQ = 4;
    localparam int OCM_IDW  = $clog2(OCM_NREQ);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ocm_port_arbiter_rr_pick.sv
// Round-robin picker: first valid bit at or above start, wrapping.
// Pure combinational; shared with the DMA channel scheduler.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Scan N positions from start, modulo N, keep the first hit.
    always_comb begin
        int  j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ocm_port_arbiter.sv
// Single OCM macro port shared by NREQ requesters.
// Round-robin with lock; drives CEN/WEN/A/D, returns tagged responses.
module ocm_port_arbiter
    import ocm_pkg::*;
#(
    parameter int NREQ = OCM_NREQ,
    parameter int AW   = OCM_AW,
    parameter int DW   = OCM_DW,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic             CEN,
    output logic             WEN,
    output logic [AW-1:0]      A,
    output logic [DW-1:0]      D,
    input  logic [DW-1:0]      Q
);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_idx;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  g_idx;
    logic            accept;

    rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_pick (
        .valid (req_valid),
        .start (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Grant: round-robin pick, or only the lock owner while locked.
    always_comb begin
        grant = arb_grant;
        g_idx = arb_idx;
        unique case (state_q)
            ARB: ;
            LOCKED: begin
                grant          = '0;
                g_idx          = owner_q;
                grant[owner_q] = req_valid[owner_q];
            end
            default: ;
        endcase
    end

    assign accept    = |grant;
    assign req_ready = grant;
    assign rsp_rdata = Q;

    // Macro port mux; A/D follow the selected index even when idle.
    always_comb begin
        CEN = !accept;
        WEN = 1'b1;
        A   = req_addr[int'(g_idx)*AW +: AW];
        D   = req_wdata[int'(g_idx)*DW +: DW];
        if (accept) WEN = !req_we[g_idx];
    end

    // Next state: advance pointer past the winner, enter/leave lock.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (accept) begin
            if (g_idx == IDW'(NREQ - 1)) ptr_d = '0;
            else                         ptr_d = g_idx + IDW'(1);
            if (req_lock[g_idx]) begin
                state_d = LOCKED;
                owner_d = g_idx;
            end else begin
                state_d = ARB;
            end
        end
    end

    // Arbiter registers and one-cycle response tag.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ARB;
            owner_q   <= '0;
            ptr_q     <= '0;
            rsp_valid <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            rsp_valid <= grant;
        end
    end

endmodule

// File: tb/tb_ocm_port_arbiter.sv
// Bench for ocm_port_arbiter: directed scenarios plus random traffic.
// Macro modelled behaviourally; expectations from a rule-level model.
module tb_ocm_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 128;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic [N-1:0]    req_valid, req_ready, req_lock, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, D, Q;
    logic            CEN, WEN;
    logic [AW-1:0]   A;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] ref_mem [16];

    int checks = 0;
    int errors = 0;

    int          m_ptr, m_owner;
    bit          m_locked;
    bit          exp_pend, exp_read;
    int          exp_idx;
    logic [DW-1:0] exp_data;

    always #5 sys_clk = ~sys_clk;

    ocm_port_arbiter dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_lock  (req_lock),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .CEN       (CEN),
        .WEN       (WEN),
        .A         (A),
        .D         (D),
        .Q         (Q)
    );

    // Write-first single-port macro, one-cycle read latency.
    always @(posedge sys_clk) begin
        if (CEN === 1'b0) begin
            if (WEN === 1'b0) begin
                mem[A[3:0]] <= D;
                Q           <= D;
            end else begin
                Q <= mem[A[3:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick();
        int j;
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input bit lk,
                           input bit we, input int addr,
                           input logic [DW-1:0] data);
        req_valid[i]          = v;
        req_lock[i]           = lk;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = AW'(addr);
        req_wdata[i*DW +: DW] = data;
    endtask

    task automatic all_idle();
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0, '0);
    endtask

    // One clock: check comb grant, step model, check response.
    task automatic cycle(input int want);
        int            g;
        logic [N-1:0]  oh;
        logic [AW-1:0] a;
        #1;
        g = -1;
        if (!sys_rst) begin
            g  = model_pick();
            oh = (g < 0) ? '0 : N'(1) << g;
            check("ready", DW'(req_ready), DW'(oh));
            check("cen", DW'(CEN), DW'(g < 0));
            if (g >= 0) begin
                check("wen", DW'(WEN), DW'(!req_we[g]));
                check("addr", DW'(A), DW'(req_addr[g*AW +: AW]));
                if (req_we[g]) check("wdata", D, req_wdata[g*DW +: DW]);
            end
            if (want != -2)
                check("order", DW'(req_ready),
                      DW'((want < 0) ? 4'b0 : 4'(1 << want)));
        end
        @(posedge sys_clk);
        if (sys_rst) begin
            m_ptr    = 0;
            m_locked = 0;
            m_owner  = 0;
            exp_pend = 0;
        end else begin
            exp_pend = (g >= 0);
            if (g >= 0) begin
                exp_idx  = g;
                exp_read = !req_we[g];
                a        = req_addr[g*AW +: AW];
                if (req_we[g]) ref_mem[a[3:0]] = req_wdata[g*DW +: DW];
                exp_data = ref_mem[a[3:0]];
                m_ptr    = (g + 1) % N;
                if (req_lock[g]) begin
                    m_locked = 1;
                    m_owner  = g;
                end else begin
                    m_locked = 0;
                end
            end
        end
        @(negedge sys_clk);
        check("rsp_valid", DW'(rsp_valid),
              DW'(exp_pend ? 4'(1 << exp_idx) : 4'b0));
        if (exp_pend && exp_read) check("rdata", rsp_rdata, exp_data);
    endtask

    initial begin
        logic [DW-1:0] pat;
        pat = {16'hDEAD, 96'h0123_4567_89AB_CDEF_0123_4567, 16'hBEEF};
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        m_ptr    = 0;
        m_owner  = 0;
        m_locked = 0;
        exp_pend = 0;
        exp_read = 0;
        exp_idx  = 0;
        exp_data = '0;

        // Reset held 3 cycles with everyone requesting reads.
        sys_rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, i, '0);
        repeat (3) cycle(-2);
        sys_rst = 1'b0;
        cycle(0);

        // Fairness: continuous requests rotate 1,2,3,0,...
        for (int i = 1; i <= 8; i++) cycle(i % N);

        // Write then read the same address on consecutive cycles.
        all_idle();
        set_req(1, 1, 0, 1, 5, pat);
        cycle(1);
        all_idle();
        set_req(2, 1, 0, 0, 5, '0);
        cycle(2);
        check("raw_rsp", DW'(rsp_valid), DW'(4'b0100));
        check("raw_data", rsp_rdata, pat);

        // Lock: req0 holds the port, including across a 2-cycle pause.
        all_idle();
        sys_rst = 1'b1;
        cycle(-2);
        sys_rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, i + 4, '0);
        req_lock[0] = 1'b1;
        cycle(0);
        cycle(0);
        req_valid[0] = 1'b0;
        cycle(-1);
        cycle(-1);
        req_valid[0] = 1'b1;
        cycle(0);
        req_lock[0] = 1'b0;
        cycle(0);
        req_valid[0] = 1'b0;
        cycle(1);
        cycle(2);
        cycle(3);

        // Wrap and skip: pointer parked at 3, only 3 and 0 request.
        all_idle();
        set_req(2, 1, 0, 0, 2, '0);
        cycle(2);
        all_idle();
        set_req(3, 1, 0, 0, 3, '0);
        set_req(0, 1, 0, 0, 0, '0);
        cycle(3);
        cycle(0);
        all_idle();
        cycle(-1);

        // Reset right after a locked read: response dropped, ARB/ptr 0.
        set_req(1, 1, 1, 0, 5, '0);
        cycle(1);
        all_idle();
        sys_rst = 1'b1;
        cycle(-2);
        check("rst_drop", DW'(rsp_valid), DW'(4'b0));
        sys_rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, i, '0);
        cycle(0);

        // Random traffic against the model.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0),
                        1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 15)),
                        {$urandom, $urandom, $urandom, $urandom});
            cycle(-2);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
